// File: rtl/exp_mailbox_pkg.sv
// Shared register map, status/control bit positions and status layout for the
// CPC expansion-port mailbox.
package exp_mailbox_pkg;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_STAT = 1'b1;

    localparam int unsigned STAT_RX_NE  = 0;
    localparam int unsigned STAT_TX_NF  = 1;
    localparam int unsigned STAT_IRQ_EN = 2;
    localparam int unsigned STAT_OVF    = 7;

    localparam int unsigned CTRL_FLUSH   = 0;
    localparam int unsigned CTRL_IRQ_EN  = 2;
    localparam int unsigned CTRL_CLR_OVF = 7;

    // Value left on the wired-AND data bus when nothing is being read.
    localparam logic [7:0] IDLE_BUS = 8'hFF;

    typedef struct packed {
        logic       ovf;
        logic [3:0] rsvd;
        logic       irq_en;
        logic       tx_not_full;
        logic       rx_not_empty;
    } stat_t;

endpackage

// File: rtl/exp_fifo.sv
// Synchronous first-word-fall-through byte FIFO with flush; a push into a full
// FIFO is accepted only when a pop happens in the same clock.
module exp_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full
);

    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_rd;
    logic          w_do_wr;

    assign empty   = (r_count == '0);
    assign full    = (r_count == CW'(DEPTH));
    assign rd_data = r_mem[r_rd_ptr];
    assign w_do_rd = rd_en & ~empty;
    assign w_do_wr = wr_en & (~full | w_do_rd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_do_wr && !w_do_rd)      r_count <= r_count + CW'(1);
            else if (!w_do_wr && w_do_rd) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr && !flush) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/exp_mailbox.sv
// Z80 expansion-port mailbox: DATA/STATUS I/O registers in front of a
// host->CPU and a CPU->host byte FIFO, with a level interrupt request.
module exp_mailbox
    import exp_mailbox_pkg::*;
#(
    parameter logic [7:0]  BASE_HI    = 8'hF8,
    parameter logic [6:0]  BASE_LO    = 7'b1110000,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        iorq,
    input  logic        rd,
    input  logic        wr,
    input  logic        m1,
    output logic [7:0]  cpu_din,
    output logic        irq,
    input  logic [7:0]  host_tx_data,
    input  logic        host_tx_valid,
    output logic        host_tx_ready,
    output logic [7:0]  host_rx_data,
    output logic        host_rx_valid,
    input  logic        host_rx_ready
);

    logic       w_sel, w_acc_rd, w_acc_wr;
    logic       w_wr_rise, w_rd_fall, w_wr_data, w_wr_ctrl, w_flush, w_pop_h2c;
    logic       w_h2c_empty, w_h2c_full, w_c2h_empty, w_c2h_full;
    logic [7:0] w_h2c_data, w_c2h_data;
    stat_t      w_stat;
    logic       w_unused_ok;

    logic r_acc_rd, r_acc_wr, r_rd_armed, r_rd_reg;
    logic r_irq_en, r_ovf, r_irq;

    assign w_sel    = iorq & ~m1 & (cpu_addr[15:8] == BASE_HI) & (cpu_addr[7:1] == BASE_LO);
    assign w_acc_rd = w_sel & rd;
    assign w_acc_wr = w_sel & wr;

    // Edge registers reset high and reads need an armed flag, so an access that
    // spans reset release only counts after the qualifier drops and returns.
    assign w_wr_rise = w_acc_wr & ~r_acc_wr;
    assign w_rd_fall = ~w_acc_rd & r_acc_rd & r_rd_armed;
    assign w_wr_data = w_wr_rise & (cpu_addr[0] == REG_DATA);
    assign w_wr_ctrl = w_wr_rise & (cpu_addr[0] == REG_STAT);
    assign w_flush   = w_wr_ctrl & cpu_dout[CTRL_FLUSH];
    assign w_pop_h2c = w_rd_fall & (r_rd_reg == REG_DATA);

    assign w_unused_ok = ^{cpu_dout[6:3], cpu_dout[1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc_rd   <= 1'b1;
            r_acc_wr   <= 1'b1;
            r_rd_armed <= 1'b0;
            r_rd_reg   <= REG_DATA;
            r_irq_en   <= 1'b0;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_acc_rd   <= w_acc_rd;
            r_acc_wr   <= w_acc_wr;
            r_rd_armed <= r_rd_armed | ~w_acc_rd;
            if (w_acc_rd) r_rd_reg <= cpu_addr[0];
            if (w_wr_ctrl) r_irq_en <= cpu_dout[CTRL_IRQ_EN];
            if (w_wr_ctrl && cpu_dout[CTRL_CLR_OVF])
                r_ovf <= 1'b0;
            else if (w_wr_data && w_c2h_full && !host_rx_ready)
                r_ovf <= 1'b1;
            r_irq <= r_irq_en & ~w_h2c_empty;
        end
    end

    exp_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_h2c (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (w_flush),
        .wr_en   (host_tx_valid & host_tx_ready),
        .wr_data (host_tx_data),
        .rd_en   (w_pop_h2c),
        .rd_data (w_h2c_data),
        .empty   (w_h2c_empty),
        .full    (w_h2c_full)
    );

    exp_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_c2h (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (w_flush),
        .wr_en   (w_wr_data),
        .wr_data (cpu_dout),
        .rd_en   (host_rx_ready),
        .rd_data (w_c2h_data),
        .empty   (w_c2h_empty),
        .full    (w_c2h_full)
    );

    assign w_stat = '{ovf: r_ovf, rsvd: 4'b0, irq_en: r_irq_en,
                      tx_not_full: ~w_c2h_full, rx_not_empty: ~w_h2c_empty};

    // Read mux; the bus idles high because the motherboard ANDs it in.
    always_comb begin
        cpu_din = IDLE_BUS;
        if (w_acc_rd) begin
            if (cpu_addr[0] == REG_STAT) cpu_din = w_stat;
            else if (!w_h2c_empty)       cpu_din = w_h2c_data;
        end
    end

    assign irq           = r_irq;
    assign host_tx_ready = ~w_h2c_full;
    assign host_rx_valid = ~w_c2h_empty;
    assign host_rx_data  = w_c2h_empty ? IDLE_BUS : w_c2h_data;

endmodule

// File: tb/tb_exp_mailbox.sv
// Self-checking bench for exp_mailbox: Z80 I/O cycles and host-side traffic
// with expected read data queued at drive time and compared at sample time.
module tb_exp_mailbox;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        iorq = 1'b0, rd = 1'b0, wr = 1'b0, m1 = 1'b0;
    logic [7:0]  cpu_din;
    logic        irq;
    logic [7:0]  host_tx_data = 8'h00;
    logic        host_tx_valid = 1'b0;
    logic        host_tx_ready;
    logic [7:0]  host_rx_data;
    logic        host_rx_valid;
    logic        host_rx_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rd_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    exp_mailbox dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cpu_addr      (cpu_addr),
        .cpu_dout      (cpu_dout),
        .iorq          (iorq),
        .rd            (rd),
        .wr            (wr),
        .m1            (m1),
        .cpu_din       (cpu_din),
        .irq           (irq),
        .host_tx_data  (host_tx_data),
        .host_tx_valid (host_tx_valid),
        .host_tx_ready (host_tx_ready),
        .host_rx_data  (host_rx_data),
        .host_rx_valid (host_rx_valid),
        .host_rx_ready (host_rx_ready)
    );

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Z80 read cycle lasting cyc clocks; data sampled just before rd drops.
    task automatic io_rd(input string tag, input logic [15:0] a, input int cyc,
                         input logic m, input logic [7:0] exp);
        logic [7:0] e;
        rd_q.push_back(exp);
        @(negedge clk);
        cpu_addr = a; iorq = 1'b1; rd = 1'b1; m1 = m;
        repeat (cyc - 1) @(negedge clk);
        #1;
        e = rd_q.pop_front();
        check8(tag, cpu_din, e);
        iorq = 1'b0; rd = 1'b0; m1 = 1'b0;
    endtask

    // Z80 write cycle; the reference model queues bytes the host should see.
    task automatic io_wr(input logic [15:0] a, input logic [7:0] d, input int cyc, input logic m);
        @(negedge clk);
        cpu_addr = a; cpu_dout = d; iorq = 1'b1; wr = 1'b1; m1 = m;
        if (a == 16'hF8E0 && !m && rx_q.size() < 16) rx_q.push_back(d);
        repeat (cyc - 1) @(negedge clk);
        iorq = 1'b0; wr = 1'b0; m1 = 1'b0;
    endtask

    task automatic host_push(input logic [7:0] d);
        @(negedge clk);
        host_tx_data = d; host_tx_valid = 1'b1;
        @(negedge clk);
        host_tx_valid = 1'b0;
    endtask

    task automatic host_drain();
        @(negedge clk);
        host_rx_ready = 1'b1;
        while (rx_q.size() > 0) begin
            check8("rx_data", host_rx_data, rx_q.pop_front());
            @(negedge clk);
        end
        host_rx_ready = 1'b0;
        check8("rx_valid_drained", 8'(host_rx_valid), 8'h00);
        check8("rx_data_idle", host_rx_data, 8'hFF);
    endtask

    initial begin
        // Reset state
        #2 reset_n = 1'b0;
        #1;
        check8("rst_cpu_din", cpu_din, 8'hFF);
        check8("rst_irq", 8'(irq), 8'h00);
        check8("rst_tx_ready", 8'(host_tx_ready), 8'h01);
        check8("rst_rx_valid", 8'(host_rx_valid), 8'h00);
        check8("rst_rx_data", host_rx_data, 8'hFF);
        @(negedge clk);
        reset_n = 1'b1;
        io_rd("stat_reset", 16'hF8E1, 2, 1'b0, 8'h02);
        @(negedge clk);
        check8("idle_cpu_din", cpu_din, 8'hFF);

        // Host->CPU data path
        host_push(8'h41);
        host_push(8'h42);
        io_rd("stat_two", 16'hF8E1, 2, 1'b0, 8'h03);
        io_rd("data_41", 16'hF8E0, 4, 1'b0, 8'h41);
        io_rd("data_42", 16'hF8E0, 4, 1'b0, 8'h42);
        io_rd("data_empty", 16'hF8E0, 4, 1'b0, 8'hFF);
        io_rd("stat_drained", 16'hF8E1, 2, 1'b0, 8'h02);

        // Interrupt
        io_wr(16'hF8E1, 8'h04, 2, 1'b0);
        host_push(8'h55);
        check8("irq_not_yet", 8'(irq), 8'h00);
        @(negedge clk);
        check8("irq_set", 8'(irq), 8'h01);
        io_rd("data_55", 16'hF8E0, 4, 1'b0, 8'h55);
        repeat (2) @(negedge clk);
        check8("irq_clear", 8'(irq), 8'h00);
        io_wr(16'hF8E1, 8'h00, 2, 1'b0);
        io_rd("stat_irq_off", 16'hF8E1, 2, 1'b0, 8'h02);

        // CPU->host overflow and drain
        for (int i = 0; i < 17; i++) io_wr(16'hF8E0, 8'(i), 2, 1'b0);
        io_rd("stat_ovf_full", 16'hF8E1, 2, 1'b0, 8'h80);
        check8("tx_ready_ovf", 8'(host_tx_ready), 8'h01);
        host_drain();
        io_rd("stat_ovf_drained", 16'hF8E1, 2, 1'b0, 8'h82);
        io_wr(16'hF8E1, 8'h80, 2, 1'b0);
        io_rd("stat_ovf_clr", 16'hF8E1, 2, 1'b0, 8'h02);

        // Long write, decode misses and M1 cycles
        io_wr(16'hF8E0, 8'hA5, 20, 1'b0);
        @(negedge clk);
        check8("long_wr_valid", 8'(host_rx_valid), 8'h01);
        host_drain();
        io_wr(16'hF8E2, 8'h5A, 3, 1'b0);
        io_wr(16'hF9E0, 8'h5A, 3, 1'b0);
        io_wr(16'hF8E0, 8'h5A, 3, 1'b1);
        io_wr(16'hF8E3, 8'h01, 3, 1'b0);
        @(negedge clk);
        check8("miss_rx_valid", 8'(host_rx_valid), 8'h00);
        host_push(8'h77);
        io_rd("rd_f9e0", 16'hF9E0, 3, 1'b0, 8'hFF);
        io_rd("rd_f8e2", 16'hF8E2, 3, 1'b0, 8'hFF);
        io_rd("rd_m1", 16'hF8E0, 3, 1'b1, 8'hFF);
        io_rd("stat_kept", 16'hF8E1, 2, 1'b0, 8'h03);
        io_rd("data_77", 16'hF8E0, 2, 1'b0, 8'h77);

        // Simultaneous push/pop at 15 entries, then flush vs push
        for (int i = 0; i < 15; i++) host_push(8'hB0 + 8'(i));
        fork
            io_rd("data_b0", 16'hF8E0, 4, 1'b0, 8'hB0);
            begin
                repeat (3) @(negedge clk);
                host_push(8'hC0);
            end
        join
        check8("tx_ready_15", 8'(host_tx_ready), 8'h01);
        host_push(8'hC1);
        check8("tx_ready_full", 8'(host_tx_ready), 8'h00);
        io_rd("data_b1", 16'hF8E0, 2, 1'b0, 8'hB1);
        fork
            io_wr(16'hF8E1, 8'h01, 2, 1'b0);
            host_push(8'hC2);
        join
        io_rd("stat_flushed", 16'hF8E1, 2, 1'b0, 8'h02);

        // Reset asserted in the middle of a read
        io_wr(16'hF8E1, 8'h04, 2, 1'b0);
        io_wr(16'hF8E0, 8'hEE, 2, 1'b0);
        host_push(8'hDD);
        repeat (2) @(negedge clk);
        check8("irq_pre_rst", 8'(irq), 8'h01);
        check8("rx_valid_pre_rst", 8'(host_rx_valid), 8'h01);
        @(negedge clk);
        cpu_addr = 16'hF8E0; iorq = 1'b1; rd = 1'b1;
        #1;
        check8("data_pre_rst", cpu_din, 8'hDD);
        #2 reset_n = 1'b0;
        #1;
        check8("mid_rst_cpu_din", cpu_din, 8'hFF);
        check8("mid_rst_irq", 8'(irq), 8'h00);
        check8("mid_rst_tx_ready", 8'(host_tx_ready), 8'h01);
        check8("mid_rst_rx_valid", 8'(host_rx_valid), 8'h00);
        check8("mid_rst_rx_data", host_rx_data, 8'hFF);
        rx_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        host_push(8'h99);
        iorq = 1'b0; rd = 1'b0;
        repeat (2) @(negedge clk);
        io_rd("stat_post_rst", 16'hF8E1, 2, 1'b0, 8'h03);
        io_rd("data_99", 16'hF8E0, 2, 1'b0, 8'h99);
        io_rd("stat_final", 16'hF8E1, 2, 1'b0, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exp_mailbox.md
Name: exp_mailbox

Overview:
Expansion-port I/O responder for the CPC motherboard. It decodes Z80 I/O cycles on the expansion bus (cpu_addr, cpu_dout, iorq, rd, wr, m1) and returns read data on cpu_din, which the motherboard ANDs into the CPU data bus. It provides two byte FIFOs between the CPU and a host controller (ARM/IO side), plus a level interrupt request on the expansion irq line.

Parameters:
BASE_HI, 8'hF8, I/O address high byte (cpu_addr[15:8]) that must match for selection
BASE_LO, 7'b1110000, match value for cpu_addr[7:1]; cpu_addr[0] selects the register
DEPTH_LOG2, 4, log2 of the depth of each FIFO (16 entries)

Ports:
clk  in  1  system clock (single clock domain)
reset_n  in  1  asynchronous active-low reset
cpu_addr  in  16  Z80 address
cpu_dout  in  8  Z80 write data
iorq  in  1  active-high IORQ
rd  in  1  active-high RD
wr  in  1  active-high WR
m1  in  1  active-high M1; qualifies out interrupt-acknowledge cycles
cpu_din  out  8  read data; 8'hFF whenever the block is not driving a read
irq  out  1  level interrupt request, active high
host_tx_data  in  8  host->CPU byte
host_tx_valid  in  1  host push request
host_tx_ready  out  1  host->CPU FIFO not full
host_rx_data  out  8  CPU->host FIFO head
host_rx_valid  out  1  CPU->host FIFO not empty
host_rx_ready  in  1  host pop; a pop occurs when host_rx_valid & host_rx_ready

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset state: both FIFOs empty, irq_en=0, ovf=0, irq=0, host_tx_ready=1, host_rx_valid=0, host_rx_data=8'hFF, cpu_din=8'hFF.
- Select: sel = iorq & ~m1 & (cpu_addr[15:8]==BASE_HI) & (cpu_addr[7:1]==BASE_LO).
- Access qualifiers: acc_rd = sel & rd; acc_wr = sel & wr.
- Edge detection: acc_rd and acc_wr are registered each clk. Each access acts once per Z80 cycle, regardless of wait states or how many clk cycles it lasts.
- Register map, reg 0 (DATA):
  - Read: cpu_din = head of the host->CPU FIFO, driven combinationally while acc_rd is high. The pop happens on the acc_rd falling edge, so data stays stable for the whole cycle. If the FIFO is empty, the read returns 8'hFF and nothing is popped.
  - Write: on the acc_wr rising edge, cpu_dout is pushed into the CPU->host FIFO. If that FIFO is full, the byte is dropped and ovf is set.
- Register map, reg 1 (STATUS/CTRL):
  - Read: {ovf, 4'b0, irq_en, tx_not_full, rx_not_empty}. Bit0 = host->CPU FIFO non-empty; bit1 = CPU->host FIFO not full.
  - Write, bit2: sets irq_en.
  - Write, bit7: writing 1 clears ovf.
  - Write, bit0: writing 1 flushes both FIFOs.
- irq: registered; irq = irq_en & host->CPU FIFO non-empty. Deasserts one clk after the FIFO becomes empty or irq_en is cleared. Acknowledge cycles (m1 & iorq) have no effect.
- Host push: host_tx_valid & host_tx_ready writes host_tx_data; STATUS bit0 reflects it the next clk.
- Host pop: first-word-fall-through; host_rx_data is valid whenever host_rx_valid=1.
- Simultaneous push and pop on one FIFO in the same clk: both take effect. Count is unchanged; a full FIFO stays full without data loss.
- Flush vs push: flush and a push in the same clk leave the FIFO empty (flush wins).
- Flush and ovf: ovf is cleared only by writing bit7, not by flush.
- Pointers: DEPTH_LOG2-bit pointers wrap modulo 2^DEPTH_LOG2. Count is DEPTH_LOG2+1 bits; full when count == 2^DEPTH_LOG2.
- Reset mid-cycle: all state is cleared immediately. If reset_n is released during an access, that access acts only on a subsequent edge, i.e. no action unless the qualifier falls and rises again.

Decomposition:
- Shared package exp_mailbox_pkg: register offsets REG_DATA=0, REG_STAT=1; STATUS bit indices; CTRL bit indices.
- One sub-module exp_fifo: synchronous FWFT FIFO, parameter DEPTH_LOG2. Ports: clk, reset_n, flush, wr_en, wr_data, rd_en, rd_data, empty, full. Instantiated twice.

Test Plan:
- Reset, then read &F8E1 -> 8'h02; cpu_din=8'hFF outside cycles; irq=0; host_tx_ready=1.
- Host pushes 8'h41, 8'h42 -> STATUS=8'h03. Three reads of &F8E0, each 4 clk wide -> 8'h41, 8'h42, 8'hFF; STATUS bit0 ends 0.
- Write &F8E1=8'h04, then host pushes 8'h55 -> irq=1 one clk later. CPU reads &F8E0 -> 8'h55; irq=0 one clk after the rd falling edge.
- CPU writes 17 bytes 8'h00..8'h10 to &F8E0 with host_rx_ready=0 -> STATUS=8'h80 (ovf set, tx full). Host drains 8'h00..8'h0F. Write &F8E1=8'h80 -> ovf clears.
- Write with wr held 20 clk under wait states -> exactly one push. Access at &F8E2 or &F9E0, or with m1=1 -> no effect; cpu_din=8'hFF.
- FIFO at 15 entries with a simultaneous host push and CPU pop -> count stays 15. Flush write plus host push in the same clk -> empty. reset_n pulsed low mid-read -> all outputs at reset values asynchronously.
